// File: rtl/wb_fwd_mux.sv
// Writeback source select with a registered writeback stage and a short history
// of recent register writes that forwards fresh results to the register-read ports.
module wb_fwd_mux #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int NSRC  = 3,
  parameter int SW    = 2,
  parameter int DEPTH = 3,
  parameter int NRD   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NSRC*DW-1:0]  wb_src,
  input  logic [SW-1:0]       wb_sel,
  input  logic [AW-1:0]       wb_addr,
  input  logic                wb_we,
  input  logic                stall,
  input  logic                flush,
  input  logic [NRD*AW-1:0]   rd_addr,
  input  logic [NRD*DW-1:0]   rf_data,
  output logic [NRD*DW-1:0]   rd_data,
  output logic [NRD-1:0]      fwd_hit,
  output logic                wb_we_q,
  output logic [AW-1:0]       wb_addr_q,
  output logic [DW-1:0]       wb_data_q
);

  logic [DW-1:0]                sel_data;
  logic                         eff_we;

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][AW-1:0]     addr_q,  addr_d;
  logic [DEPTH-1:0][DW-1:0]     data_q,  data_d;

  // Out-of-range selects resolve to zero rather than an undefined source.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (int'(wb_sel) == k) sel_data = wb_src[k*DW +: DW];
    end
  end

  assign eff_we = wb_we && (wb_addr != '0);

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = '0;
    end else if (!stall) begin
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        addr_d[i]  = addr_q[i-1];
        data_d[i]  = data_q[i-1];
      end
      valid_d[0] = eff_we;
      addr_d[0]  = wb_addr;
      data_d[0]  = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign wb_we_q   = valid_q[0];
  assign wb_addr_q = addr_q[0];
  assign wb_data_q = data_q[0];

  // Scan oldest to newest so the lowest-index (newest) match is the one kept.
  always_comb begin
    rd_data = rf_data;
    fwd_hit = '0;
    for (int p = 0; p < NRD; p++) begin
      if (rd_addr[p*AW +: AW] != '0) begin
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (valid_q[i] && (addr_q[i] == rd_addr[p*AW +: AW])) begin
            fwd_hit[p]           = 1'b1;
            rd_data[p*DW +: DW]  = data_q[i];
          end
        end
      end
    end
  end

endmodule
